// File: rtl/cla_pkg.sv
// Shared definitions for the chunked CLA adder: chunk size, FSM states and
// the chunk-count helper used to size the sequencing logic.
package cla_pkg;

  localparam int CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int chunk_count(input int width);
    return width / CHUNK;
  endfunction

endpackage

// File: rtl/CLA_16_bit_block.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups whose group
// generate/propagate terms are chained to form the inter-group carries.
module CLA_16_bit_block
  import cla_pkg::*;
(
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic [3:0]       gg;
  logic [3:0]       gp;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group lookahead carries, then group G/P chained into the next group.
  always_comb begin
    c    = '0;
    gg   = '0;
    gp   = '0;
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/cla_chunked_adder.sv
// Multi-cycle WIDTH-bit adder built around one 16-bit CLA. Operands are
// captured on accept, then added one 16-bit chunk per cycle (LSB first) with
// the chunk carry held in a register between cycles.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready and out_valid are decoded from the state register only, so
// neither depends combinationally on in_valid or out_ready; out_valid stays
// high with sum/cout/ovf frozen until the consumer takes the result.
module cla_chunked_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int N    = chunk_count(WIDTH);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_width_check
    $error("cla_chunked_adder: WIDTH must be a non-zero multiple of 16");
  end

  cla_state_t       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] cla_a;
  logic [CHUNK-1:0] cla_b;
  logic [CHUNK-1:0] cla_sum;
  logic             cla_cout;

  assign cla_a = a_reg[idx*CHUNK +: CHUNK];
  assign cla_b = b_reg[idx*CHUNK +: CHUNK];

  CLA_16_bit_block u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Sequencer: capture operands, walk the chunks, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= cla_sum;
          carry                   <= cla_cout;
          if (idx == LAST_IDX) begin
            cout  <= cla_cout;
            // Top chunk's MSB is the sum's sign bit.
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (cla_sum[CHUNK-1] != a_reg[WIDTH-1]);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_chunked_adder.sv
// Bench for cla_chunked_adder: one directed lane at WIDTH=64 and randomized
// lanes at WIDTH=16, 32 and 128, each with its own expected-result queue.
module tb_cla_chunked_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [131:0] act,
                       input logic [131:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int W = (g == 0) ? 64 : (g == 1) ? 16 : (g == 2) ? 32 : 128;

    logic         lane_rst_n;
    logic         mid_rst_n = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic [1:0]   dbg_state;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_exp;
    bit           done = 1'b0;

    assign lane_rst_n = rst_n & mid_rst_n;

    cla_chunked_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (lane_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy),
      .dbg_state (dbg_state)
    );

    // Reference: {ovf, cout, sum} of a + b + cin at W bits.
    function automatic logic [W+1:0] model(input logic [W-1:0] av,
                                           input logic [W-1:0] bv,
                                           input logic cv);
      logic [W:0] s;
      logic       o;
      s = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      o = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
      return {o, s};
    endfunction

    function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W / 16; i++) begin
        case ($urandom_range(0, 5))
          0:       v[i*16 +: 16] = 16'hFFFF;
          1:       v[i*16 +: 16] = 16'h0000;
          default: v[i*16 +: 16] = 16'($urandom);
        endcase
      end
      return v;
    endfunction

    // Monitor: every taken result must match the oldest expected entry.
    always @(negedge clk) begin
      if (lane_rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL w%0d_unexpected_result actual=%0h required=none",
                   W, {ovf, cout, sum});
        end else begin
          mon_exp = exp_q.pop_front();
          check($sformatf("w%0d_result", W), {ovf, cout, sum}, mon_exp);
        end
      end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input bit push);
      int t;
      t        = 0;
      a        = av;
      b        = bv;
      cin      = cv;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("w%0d_accept", W), in_ready, 1);
      if (in_ready) begin
        @(posedge clk);
        if (push) exp_q.push_back(model(av, bv, cv));
        #1;
      end
      in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("w%0d_valid_seen", W), out_valid, 1);
    endtask

    task automatic drain();
      for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
      check($sformatf("w%0d_drain", W), exp_q.size(), 0);
    endtask

    if (g == 0) begin : g_directed
      initial begin
        int           lat;
        logic [W+1:0] e;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        @(posedge rst_n);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
        wait_valid(lat);
        check("t1_latency", lat, 4);
        check("t1_sum", sum, 0);
        check("t1_cout", cout, 1);
        check("t1_ovf", ovf, 0);

        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
        wait_valid(lat);
        check("t2_sum", sum, 64'h8000_0000_0000_0000);
        check("t2_cout", cout, 0);
        check("t2_ovf", ovf, 1);

        send(64'h0, 64'h0, 1'b1, 1'b1);
        wait_valid(lat);
        check("t3_sum", sum, 64'h1);

        send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b1);
        wait_valid(lat);
        check("t4_sum", sum, 64'h0001_0000_0001_0000);
        check("t4_cout", cout, 0);
        @(posedge clk);
        #1;
        check("t4_in_ready_after_take", in_ready, 1);

        // Backpressure in DONE, with a stray request that must be ignored.
        out_ready = 1'b0;
        e = model(64'h8000_0000_1234_5678, 64'h8000_0000_FFFF_FFFF, 1'b1);
        send(64'h8000_0000_1234_5678, 64'h8000_0000_FFFF_FFFF, 1'b1, 1'b1);
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          if (k == 1) begin
            a        = 64'h1111_1111_1111_1111;
            b        = 64'h2222_2222_2222_2222;
            in_valid = 1'b1;
          end
          if (k == 3) in_valid = 1'b0;
          @(negedge clk);
          check("bp_result_stable", {ovf, cout, sum}, e);
          check("bp_in_ready_low", in_ready, 0);
          check("bp_out_valid_held", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after_take", in_ready, 1);
        check("bp_out_valid_after_take", out_valid, 0);
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
        wait_valid(lat);
        check("bp_next_latency", lat, 4);

        // Asynchronous reset in the middle of RUN discards the operation.
        send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        mid_rst_n = 1'b0;
        #1;
        check("mrst_sum", sum, 0);
        check("mrst_cout", cout, 0);
        check("mrst_ovf", ovf, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        @(posedge clk);
        #1;
        mid_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          check("mrst_no_result", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(64'hDEAD_BEEF_0000_FFFF, 64'h2152_4111_FFFF_0001, 1'b0, 1'b1);
        wait_valid(lat);
        check("mrst_fresh_latency", lat, 4);

        drain();
        done = 1'b1;
      end
    end else begin : g_random
      initial begin
        out_ready = 1'b0;
        forever begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end

      initial begin
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        @(posedge rst_n);
        @(posedge clk);
        #1;
        for (int i = 0; i < 1000; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          send(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        done = 1'b1;
      end
    end
  end

  // Clock/reset and end-of-run report.
  initial begin
    bit all_done;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_lane[0].done && g_lane[1].done &&
                 g_lane[2].done && g_lane[3].done;
    end
    check("run_complete", all_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
